// File: rtl/wide_add_ctrl_if.sv
// Operand/result bundle for the multi-cycle wide adder.
// master drives the request side, slave is the adder.
interface wide_add_ctrl_if #(
  parameter int N     = 16,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/wide_add_ctrl.sv
// Wide add/sub built from one N-bit slice reused once per cycle.
// Result words fill in LSB first; done marks the final value.
module wide_add_ctrl #(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  wide_add_ctrl_if.slave bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     cy_q, cy_d;
  logic                     sub_q, sub_d;
  logic [WORDS-1:0][N-1:0]  a_q, a_d;
  logic [WORDS-1:0][N-1:0]  b_q, b_d;
  logic [WORDS-1:0][N-1:0]  sum_q, sum_d;
  logic                     cout_q, cout_d;
  logic                     ovf_q, ovf_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [N-1:0]             a_w;
  logic [N-1:0]             bx;
  logic [N-1:0]             s;
  logic                     c;
  logic                     last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    a_w      = a_q[idx_q];
    bx       = sub_q ? ~b_q[idx_q] : b_q[idx_q];
    {c, s}   = {1'b0, a_w} + {1'b0, bx} + {{N{1'b0}}, cy_q};
    last     = (idx_q == IW'(WORDS - 1));

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          idx_d   = '0;
          cy_d    = bus.sub;
        end
      end
      RUN: begin
        sum_d[idx_q] = s;
        cy_d         = c;
        // Hold idx on the top slice so it never wraps.
        if (last) begin
          state_d = DONE;
          cout_d  = c;
          ovf_d   = (a_w[N-1] == bx[N-1]) &&
                    (s[N-1] != a_w[N-1]);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_wide_add_ctrl.sv
// Self-checking bench for wide_add_ctrl: vector table,
// scoreboard on done, plus abort/ignore/back-to-back runs.
module tb_wide_add_ctrl;
  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;
  exp_t sbq[$];

  wide_add_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();

  wide_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic sub);
    vec_t         v;
    logic [W:0]   r;
    logic [W-1:0] eb;
    eb    = sub ? ~b : b;
    r     = {1'b0, a} + {1'b0, eb} + (W + 1)'(sub);
    v.a   = a;
    v.b   = b;
    v.sub = sub;
    v.s   = r[W-1:0];
    v.co  = r[W];
    v.ov  = (a[W-1] == eb[W-1]) && (r[W-1] != a[W-1]);
    return v;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.done === 1'b1) begin
      n_done++;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 want no result");
      end else begin
        e = sbq.pop_front();
        chk("sum",  bus.sum, e.s);
        chk("cout", W'(bus.cout), W'(e.co));
        chk("ovf",  W'(bus.ovf),  W'(e.ov));
      end
    end
  end

  task automatic run_op(input vec_t v);
    int   cnt;
    exp_t e;
    @(negedge clk);
    bus.a     = v.a;
    bus.b     = v.b;
    bus.sub   = v.sub;
    bus.start = 1'b1;
    e.s  = v.s;
    e.co = v.co;
    e.ov = v.ov;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = {$urandom, $urandom};
    bus.b     = {$urandom, $urandom};
    bus.sub   = ~v.sub;
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", W'(cnt), W'(WORDS));
    @(negedge clk);
    chk("idle_busy", W'(bus.busy), '0);
    chk("done_pulse", W'(bus.done), '0);
    chk("sum_hold", bus.sum, v.s);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    int   cnt;
    int   d0;
    int   dc[$];
    int   lowc;

    tbl[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h0, 1'b1, 1'b0};
    tbl[2] = '{64'h0, 64'h1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[5] = '{64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b0};
    tbl[6] = '{64'h1234_5678_9ABC_DEF0,
               64'h0FED_CBA9_8765_4321, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0};
    for (int i = 7; i < 11; i++)
      tbl[i] = model({$urandom, $urandom},
                     {$urandom, $urandom}, 1'(i & 1));

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_sum",  bus.sum, '0);
    chk("rst_cout", W'(bus.cout), '0);
    chk("rst_ovf",  W'(bus.ovf), '0);
    // start must lose to rst on the same edge
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_prio_busy", W'(bus.busy), '0);
    bus.start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_op(tbl[i]);

    // start and operand changes during RUN are ignored
    d0 = n_done;
    @(negedge clk);
    bus.a = 64'd5; bus.b = 64'd6; bus.sub = 1'b0;
    bus.start = 1'b1;
    v = model(64'd5, 64'd6, 1'b0);
    sbq.push_back('{v.s, v.co, v.ov});
    @(negedge clk);
    bus.a = 64'd100; bus.b = 64'd200; bus.sub = 1'b1;
    @(negedge clk);
    bus.a = 64'd999;
    bus.start = 1'b0;
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("ign_latency", W'(cnt), W'(WORDS - 1));
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("ign_no_restart", W'(cnt), '0);
    chk("ign_one_done", W'(n_done - d0), W'(1));

    // reset in the second RUN cycle aborts with no done
    d0 = n_done;
    @(negedge clk);
    bus.a = 64'hFFFF_FFFF_FFFF_FFFE; bus.b = 64'h1;
    bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_done", W'(bus.done), '0);
    chk("abort_sum",  bus.sum, '0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", W'(n_done - d0), '0);
    run_op(model(64'd3, 64'd4, 1'b0));

    // start held high: one issue every WORDS+2 cycles
    @(negedge clk);
    bus.a = 64'h0000_0001_0000_FFFF; bus.b = 64'h3;
    bus.sub = 1'b0; bus.start = 1'b1;
    v = model(bus.a, bus.b, 1'b0);
    repeat (4) sbq.push_back('{v.s, v.co, v.ov});
    lowc = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dc.push_back(i);
      if (dc.size() >= 1 && dc.size() < 4 && !bus.busy)
        lowc++;
      if (i == 19) bus.start = 1'b0;
    end
    chk("b2b_count", W'(dc.size()), W'(4));
    for (int k = 1; k < dc.size(); k++)
      chk("b2b_interval", W'(dc[k] - dc[k-1]),
          W'(WORDS + 2));
    chk("b2b_idle_gaps", W'(lowc), W'(3));

    repeat (4) @(negedge clk);
    chk("queue_empty", W'(sbq.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wide_add_ctrl.md
WIDE_ADD_CTRL -- requirements
Module: wide_add_ctrl

Interface
REQ-001 Parameter N, default 16, SHALL set the width in bits of the single adder slice.
REQ-002 Parameter WORDS, default 4, SHALL set the number of slices per operation; WORDS >= 2 and operand width W = N*WORDS.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port start, input, 1, SHALL request an operation; it is sampled only in IDLE.
REQ-006 Port sub, input, 1, SHALL select subtraction (1) or addition (0); it is sampled with start.
REQ-007 Port a, input, W, SHALL be operand A; it is sampled with start.
REQ-008 Port b, input, W, SHALL be operand B; it is sampled with start.
REQ-009 Port busy, output, 1, SHALL be high in RUN and DONE.
REQ-010 Port done, output, 1, SHALL be a one-cycle pulse marking the result as valid.
REQ-011 Port sum, output, W, SHALL carry the result A+B or A-B, modulo 2^W.
REQ-012 Port cout, output, 1, SHALL be the carry out of the top slice; for subtraction it is the not-borrow flag.
REQ-013 Port ovf, output, 1, SHALL flag two's-complement signed overflow of the full W-bit result.

Function
REQ-014 The block SHALL contain exactly one N-bit add slice: operands opA_word + (sub ? ~opB_word : opB_word) + carry. The slice SHALL be reused once per cycle.
REQ-015 The FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE -> RUN when start=1. On that edge the block SHALL:
- register a, b and sub;
- set the word index idx=0;
- set the carry register to sub.
REQ-017 In IDLE with start=0, the state SHALL remain IDLE.
REQ-018 In each RUN cycle the block SHALL:
- add slice idx (bits idx*N+N-1 : idx*N);
- write the slice result into sum at that position;
- register the slice carry-out as the carry for the next slice;
- increment idx.
REQ-019 RUN -> DONE on the edge that processes idx=WORDS-1. cout and ovf SHALL be updated on that same edge from the top slice.
REQ-020 ovf SHALL be (sign of A) == (sign of effective B) and sign of sum != sign of A, where effective B is ~B for subtraction.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 Latency: start sampled at edge E0 -> done high in the cycle following edge E(WORDS). For the default, done is high in the cycle after the 4th edge following acceptance.
REQ-023 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued. a, b and sub changing during RUN SHALL NOT affect the result.
REQ-024 Back-to-back: start held high SHALL be accepted on the first IDLE edge after DONE. The minimum issue interval is WORDS+2 cycles.
REQ-025 sum, cout and ovf SHALL hold their last value from DONE until the next accepted start. Intermediate partial sum words are visible during RUN; consumers SHALL qualify them with done.
REQ-026 Wrap-around: a carry out of the top slice SHALL NOT alter sum; it SHALL appear only on cout.
REQ-027 idx SHALL be ceil(log2(WORDS)) bits wide and SHALL NOT wrap during a legal operation.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL go to IDLE and clear busy, done, sum, cout, ovf, idx and the carry register to 0, regardless of state.
REQ-029 rst SHALL take priority over start on the same edge.
REQ-030 rst asserted mid-RUN SHALL abort the operation with no done pulse. The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-031 Carry chain across all words: a=0x0000_0000_0000_FFFF, b=1, sub=0 -> done after 4 cycles, sum=0x0000_0000_0001_0000, cout=0, ovf=0.
REQ-032 Full wrap-around and carry out: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0, cout=1, ovf=0.
REQ-033 Subtraction with borrow and signed overflow: a=0, b=1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0. a=0x8000_0000_0000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
REQ-034 Ignored start and operand changes: pulse start with new operands during RUN and change a mid-RUN -> the result matches the original operands, exactly one done pulse, and no second operation starts.
REQ-035 Reset mid-operation: rst=1 at the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0; a subsequent start computes 3+4 = 7 correctly.
REQ-036 Back-to-back issue: start held high for 20 cycles -> done pulses every 6 cycles and busy drops for exactly one IDLE cycle between operations.
